// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32-cycle multiplier that borrows the shared execute-stage ALU for its adds.
// Optional: define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [XLEN-1:0] OpAE,
  input  logic [XLEN-1:0] OpBE,
  input  logic            FlushE,
  input  logic [XLEN-1:0] AluResult,
  output logic            AluOwn,
  output logic [XLEN-1:0] AluSrcA,
  output logic [XLEN-1:0] AluSrcB,
  output logic [2:0]      AluControl,
  output logic            StallE,
  output logic            MulDone,
  output logic [XLEN-1:0] MulResult
);

`ifdef MUL_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    AluOwn     = 1'b0;
    AluSrcA    = '0;
    AluSrcB    = '0;
    AluControl = 3'b000;
    StallE     = 1'b0;
    MulDone    = 1'b0;

    case (state_q)
      IDLE: begin
        if (StartE) begin
          acc_d    = '0;
          mcand_d  = OpAE;
          mplier_d = OpBE;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        StallE = 1'b1;
        if (EarlyExit && (mplier_q == '0)) begin
          result_d = acc_q;
          state_d  = DONE;
        end else begin
          AluOwn     = 1'b1;
          AluSrcA    = acc_q;
          AluSrcB    = mplier_q[0] ? mcand_q : '0;
          AluControl = 3'b000;
          acc_d      = AluResult;
          mcand_d    = mcand_q << 1;
          mplier_d   = mplier_q >> 1;
          cnt_d      = cnt_q + 5'd1;
          // The last add's sum goes straight into the result on the DONE entry edge.
          if (cnt_q == 5'd31) begin
            result_d = AluResult;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        StallE  = 1'b1;
        MulDone = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush beats start and any completion; the published result is left untouched.
    if (FlushE) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  assign MulResult = result_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer; the shared ALU is modelled by a continuous add.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        StartE, FlushE;
  logic [31:0] OpAE, OpBE, AluResult;
  logic        AluOwn, StallE, MulDone;
  logic [31:0] AluSrcA, AluSrcB, MulResult;
  logic [2:0]  AluControl;

  int n_vec = 0;
  int n_bad = 0;

  alu_mul_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .OpAE(OpAE), .OpBE(OpBE),
    .FlushE(FlushE), .AluResult(AluResult), .AluOwn(AluOwn),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluControl(AluControl),
    .StallE(StallE), .MulDone(MulDone), .MulResult(MulResult)
  );

  always #5 clk = ~clk;

  // Shared ALU: returns junk when the sequencer does not own it, so a stray capture shows up.
  assign AluResult = !AluOwn ? 32'hDEAD_BEEF :
                     (AluControl == 3'b000) ? (AluSrcA + AluSrcB) : (AluSrcA - AluSrcB);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hibit(input logic [31:0] b);
    int h = -1;
    for (int i = 0; i < 32; i++) if (b[i]) h = i;
    return h;
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    if (b == 32'd0) return 2;
    return (hibit(b) + 3 > 33) ? 33 : hibit(b) + 3;
`else
    return 33;
`endif
  endfunction

  function automatic int exp_own(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    if (b == 32'd0) return 0;
    return (hibit(b) + 1 > 32) ? 32 : hibit(b) + 1;
`else
    return 32;
`endif
  endfunction

  // Issues a start in the current (IDLE) cycle and returns #1 into the MulDone cycle.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    int cyc, own_n, bad;
    StartE = 1'b1; OpAE = a; OpBE = b;
    @(posedge clk); #1;
    StartE = 1'b0;
    cyc = 1; own_n = 0; bad = 0;
    while (!MulDone && cyc < 40) begin
      if (!StallE) bad++;
      if (AluOwn) begin
        own_n++;
        if (AluControl != 3'b000) bad++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", cyc, exp_lat(b));
    chk("result", MulResult, p);
    chk("run_flags", bad, 0);
    chk("own_cycles", own_n, exp_own(b));
    chk("done_own_stall", {30'd0, AluOwn, StallE}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] prev;
    int cyc, seen;

    vecs[0] = '{32'd3,         32'd5,         32'd15};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE};
    vecs[2] = '{32'h0001_0000, 32'h0001_0000, 32'd0};
    vecs[3] = '{32'd6,         32'd7,         32'd42};
    vecs[4] = '{32'd7,         32'd1,         32'd7};
    vecs[5] = '{32'h1234_5678, 32'd0,         32'd0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vecs[7] = '{32'h8000_0000, 32'd3,         32'h8000_0000};
    vecs[8] = '{32'h0000_1234, 32'h0000_0100, 32'h0012_3400};
    vecs[9] = '{32'd2,         32'h8000_0000, 32'd0};

    rst = 1'b1; StartE = 1'b0; FlushE = 1'b0; OpAE = '0; OpBE = '0;
    #2;
    chk("rst_stall", {31'd0, StallE}, 32'd0);
    chk("rst_own", {31'd0, AluOwn}, 32'd0);
    chk("rst_done", {31'd0, MulDone}, 32'd0);
    chk("rst_result", MulResult, 32'd0);
    chk("rst_srca", AluSrcA, 32'd0);
    chk("rst_srcb_ctl", AluSrcB | {29'd0, AluControl}, 32'd0);
    #10 rst = 1'b0;

    // First start lands on the first edge after reset release.
    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].p);
      @(posedge clk); #1;
      chk("post_done", {30'd0, MulDone, StallE}, 32'd0);
      chk("held_result", MulResult, vecs[i].p);
    end

    // Flush in cycle 10 of RUN.
    prev = MulResult;
    StartE = 1'b1; OpAE = 32'd3; OpBE = 32'h8000_0003;
    @(posedge clk); #1;
    StartE = 1'b0;
    seen = 0;
    for (cyc = 1; cyc < 10; cyc++) begin
      if (MulDone) seen++;
      @(posedge clk); #1;
    end
    FlushE = 1'b1;
    @(posedge clk); #1;
    FlushE = 1'b0;
    chk("flush_stall", {31'd0, StallE}, 32'd0);
    chk("flush_own", {31'd0, AluOwn}, 32'd0);
    chk("flush_srca", AluSrcA, 32'd0);
    chk("flush_result", MulResult, prev);
    for (int k = 0; k < 30; k++) begin
      if (MulDone) seen++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", seen, 0);

    // Flush wins over start in the same IDLE cycle.
    StartE = 1'b1; FlushE = 1'b1; OpAE = 32'd5; OpBE = 32'd5;
    @(posedge clk); #1;
    StartE = 1'b0; FlushE = 1'b0;
    chk("flush_beats_start", {31'd0, StallE}, 32'd0);

    // Start during RUN ignored, then back-to-back start after DONE.
    StartE = 1'b1; OpAE = 32'd3; OpBE = 32'd5;
    @(posedge clk); #1;
    OpAE = 32'd9; OpBE = 32'd9;
    repeat (3) begin
      @(posedge clk); #1;
    end
    StartE = 1'b0;
    cyc = 4;
    while (!MulDone && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ignored_start_lat", cyc, exp_lat(32'd5));
    chk("ignored_start_res", MulResult, 32'd15);
    @(posedge clk); #1;
    run_mul(32'd9, 32'd9, 32'd81);

    // Flush during DONE keeps the pulse and the result.
    @(posedge clk); #1;
    run_mul(32'd11, 32'd13, 32'd143);
    FlushE = 1'b1;
    #1;
    chk("flush_done_pulse", {31'd0, MulDone}, 32'd1);
    @(posedge clk); #1;
    FlushE = 1'b0;
    chk("flush_done_idle", {30'd0, MulDone, StallE}, 32'd0);
    chk("flush_done_result", MulResult, 32'd143);

    // Asynchronous reset mid-RUN in cycle 5.
    StartE = 1'b1; OpAE = 32'd3; OpBE = 32'h8000_0005;
    @(posedge clk); #1;
    StartE = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_stall_own", {30'd0, StallE, AluOwn}, 32'd0);
    chk("mid_rst_done", {31'd0, MulDone}, 32'd0);
    chk("mid_rst_result", MulResult, 32'd0);
    chk("mid_rst_srca", AluSrcA, 32'd0);
    rst = 1'b0;
    run_mul(32'd6, 32'd7, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
